multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/aludec.sv | 35 +++
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALUOp plus instruction function bits onto the
// ALU operation code.
module aludec
  import riscv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // Subtract only for R-type with instr[30] set; I-type add ignores instr[30].
  always_comb begin
    o_alu_control = ALUCTL_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALUCTL_ADD;
      ALUOP_SUB: o_alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000: begin
            if (i_op5 && i_funct7b5) o_alu_control = ALUCTL_SUB;
            else                     o_alu_control = ALUCTL_ADD;
          end
          3'b010:  o_alu_control = ALUCTL_SLT;
          3'b110:  o_alu_control = ALUCTL_OR;
          3'b111:  o_alu_control = ALUCTL_AND;
          default: o_alu_control = ALUCTL_ADD;
        endcase
      end
      default: o_alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore datapath controls per state, with the
// MemReady/Zero-qualified write enables and all enables suppressed during reset.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_mem_ready;
  logic [1:0] w_alu_op;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_illegal;

  assign w_mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state and Moore controls; the wait states hold until memory is ready.
  always_comb begin
    w_next_state = S_FETCH;
    w_alu_op     = ALUOP_ADD;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_illegal    = 1'b0;
    AdrSrc       = ADR_PC;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ResultSrc    = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_ir_write = w_mem_ready;
        w_pc_write = w_mem_ready;
        if (w_mem_ready) w_next_state = S_DECODE;
        else             w_next_state = S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECR;
          OP_IALU:      w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default: begin
            w_next_state = S_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW)      w_next_state = S_MEMREAD;
        else if (op == OP_SW) w_next_state = S_MEMWRITE;
        else                  w_next_state = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc = ADR_ALUOUT;
        if (w_mem_ready) w_next_state = S_MEMWB;
        else             w_next_state = S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = ADR_ALUOUT;
        w_mem_write = 1'b1;
        if (w_mem_ready) w_next_state = S_FETCH;
        else             w_next_state = S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RD1;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RD1;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = Zero;
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_ALUWB;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_IALU: ImmSrc = IMM_I;
      OP_SW:          ImmSrc = IMM_S;
      OP_BEQ:         ImmSrc = IMM_B;
      OP_JAL:         ImmSrc = IMM_J;
      default:        ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite  = w_pc_write  & reset;
  assign IRWrite  = w_ir_write  & reset;
  assign RegWrite = w_reg_write & reset;
  assign MemWrite = w_mem_write & reset;
  assign Illegal  = w_illegal   & reset;

  aludec u_aludec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an instruction-level reference model builds the expected
// per-cycle state walk and controls; each test compares every cycle.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  int n_cmp;
  int n_err;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 ER = 6, EI = 7, WB = 8, BQ = 9, JL = 10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BE = 7'b1100011, JA = 7'b1101111;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed controls packed as {PCW,IRW,RegW,MemW,Ill,Adr,A,B,Res,Imm,ALUCtl}
  function automatic logic [16:0] observe();
    return {PCWrite, IRWrite, RegWrite, MemWrite, Illegal, AdrSrc,
            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BE) || (o == JA);
  endfunction

  // Control table straight from the state descriptions.
  function automatic logic [16:0] exp_ctrl(input int st, input bit mr, input bit z,
                                           input bit rst_low, input logic [6:0] o,
                                           input logic [2:0] f3, input bit f7);
    bit pcw, irw, rw, mw, ill, adr;
    logic [1:0] a, b, rs, imm, aop;
    logic [2:0] ac;
    {pcw, irw, rw, mw, ill, adr} = 6'b000000;
    a = 2'd0; b = 2'd0; rs = 2'd0; aop = 2'd0;
    case (st)
      F:   begin b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
      D:   begin a = 2'd1; b = 2'd1; ill = !legal(o); end
      MA:  begin a = 2'd2; b = 2'd1; end
      MR:  adr = 1'b1;
      MWB: begin rs = 2'd1; rw = 1'b1; end
      MW:  begin adr = 1'b1; mw = 1'b1; end
      ER:  begin a = 2'd2; aop = 2'd2; end
      EI:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      WB:  rw = 1'b1;
      BQ:  begin a = 2'd2; aop = 2'd1; pcw = z; end
      JL:  begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      default: ;
    endcase
    if (rst_low) {pcw, irw, rw, mw, ill} = 5'b00000;
    imm = (o == SW) ? 2'd1 : (o == BE) ? 2'd2 : (o == JA) ? 2'd3 : 2'd0;
    if (aop == 2'd1) ac = 3'd1;
    else if (aop == 2'd0) ac = 3'd0;
    else if (f3 == 3'd2) ac = 3'd5;
    else if (f3 == 3'd6) ac = 3'd3;
    else if (f3 == 3'd7) ac = 3'd2;
    else if (f3 == 3'd0 && o[5] && f7) ac = 3'd1;
    else ac = 3'd0;
    return {pcw, irw, rw, mw, ill, adr, a, b, rs, imm, ac};
  endfunction

  // Run one instruction; fst/mst = stall cycles in FETCH and in the memory
  // wait state; rst_at = cycle index at which reset drops (-1 = never).
  task automatic apply_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                             input bit z, input int fst, input int mst, input int rst_at);
    int st_q[$];
    bit mr_q[$];
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < fst; k++) begin st_q.push_back(F); mr_q.push_back(1'b0); end
    st_q.push_back(F); mr_q.push_back(1'b1);
    st_q.push_back(D); mr_q.push_back(1'($urandom));
    if (o == LW || o == SW) begin
      st_q.push_back(MA); mr_q.push_back(1'($urandom));
      for (int k = 0; k < mst; k++) begin
        st_q.push_back((o == LW) ? MR : MW); mr_q.push_back(1'b0);
      end
      st_q.push_back((o == LW) ? MR : MW); mr_q.push_back(1'b1);
      if (o == LW) begin st_q.push_back(MWB); mr_q.push_back(1'($urandom)); end
    end else if (o == RT || o == IT) begin
      st_q.push_back((o == RT) ? ER : EI); mr_q.push_back(1'($urandom));
      st_q.push_back(WB); mr_q.push_back(1'($urandom));
    end else if (o == BE) begin
      st_q.push_back(BQ); mr_q.push_back(1'($urandom));
    end else if (o == JA) begin
      st_q.push_back(JL); mr_q.push_back(1'($urandom));
      st_q.push_back(WB); mr_q.push_back(1'($urandom));
    end
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      reset    = (i == rst_at) ? 1'b0 : 1'b1;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      Zero     = z;
      MemReady = mr_q[i];
      #1;
      obs_q.push_back(observe());
      exp_q.push_back(exp_ctrl(st_q[i], mr_q[i], z, (i == rst_at), o, f3, f7));
      if (i == rst_at) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      Zero = 1'b1; MemReady = 1'b1;
      #1;
      n_cmp++;
      if (observe() & 17'h1F000 !== 17'h00000) begin
        n_err++;
        $display("FAIL reset_enables cycle %0d: got %b expected 00000", i, observe() >> 12);
      end
    end
  endtask

  task automatic test_lw();
    apply_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
      n_cmp++;
      if (obs_q[i][14] !== (i == 4) || obs_q[i][4:3] !== 2'b00) begin
        n_err++;
        $display("FAIL lw_regwrite_imm cycle %0d: got %b/%b expected %b/00",
                 i, obs_q[i][14], obs_q[i][4:3], (i == 4));
      end
    end
  endtask

  task automatic test_sw_stall();
    int run;
    apply_instr(SW, 3'b010, 1'b0, 1'b0, 1, 2, -1);
    run = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][13] === 1'b1) run++;
    end
    n_cmp++;
    if (run != 3) begin
      n_err++;
      $display("FAIL sw_memwrite_cycles: got %0d expected 3", run);
    end
  endtask

  task automatic test_alu_types();
    logic [6:0] ops[3] = '{RT, RT, IT};
    bit f7s[3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] want[3] = '{3'b001, 3'b000, 3'b000};
    for (int t = 0; t < 3; t++) begin
      apply_instr(ops[t], 3'b000, f7s[t], 1'b0, 0, 0, -1);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL alu%0d cycle %0d: got %b expected %b", t, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_q[2][2:0] !== want[t]) begin
        n_err++;
        $display("FAIL alu%0d_control: got %b expected %b", t, obs_q[2][2:0], want[t]);
      end
    end
  endtask

  task automatic test_beq();
    for (int zz = 0; zz < 2; zz++) begin
      apply_instr(BE, 3'b000, 1'b0, zz[0], 0, 0, -1);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL beq_z%0d cycle %0d: got %b expected %b", zz, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_q[2][16] !== zz[0]) begin
        n_err++;
        $display("FAIL beq_pcwrite z=%0d: got %b expected %b", zz, obs_q[2][16], zz[0]);
      end
    end
  endtask

  task automatic test_jal();
    apply_instr(JA, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL jal cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({obs_q[2][16], obs_q[3][14], obs_q[3][6:5], obs_q[3][4:3]} !== 6'b110011) begin
      n_err++;
      $display("FAIL jal_key: got %b expected 110011",
               {obs_q[2][16], obs_q[3][14], obs_q[3][6:5], obs_q[3][4:3]});
    end
  endtask

  task automatic test_illegal_and_reset();
    apply_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][12] !== (i == 1)) begin
        n_err++;
        $display("FAIL illegal cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    apply_instr(SW, 3'b000, 1'b0, 1'b0, 0, 1, 3);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_midop cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] pool[6] = '{LW, SW, RT, IT, BE, JA};
    logic [6:0] o;
    for (int n = 0; n < 60; n++) begin
      int pick = $urandom_range(0, 6);
      if (pick == 6) begin
        o = 7'($urandom);
        if (legal(o)) o = 7'b1111111;
      end else begin
        o = pool[pick];
      end
      apply_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random%0d op=%b cycle %0d: got %b expected %b",
                   n, o, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_types();
    test_beq();
    test_jal();
    test_illegal_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
